sum_capture_fifo: RTL and testbench
===================================

Name: sum_capture_fifo

Overview:
- Downstream consumer of the 4-bit ripple adder result (4-bit sum plus carry-out).
- On each rising edge of an external sample strobe, captures {carry, sum} with a sequence tag into a small FIFO.
- The management SoC drains the FIFO over the Wishbone slave port.
- Raises an interrupt while results are pending, so software can log adder outputs without polling the GPIO pads.

Parameters:
- DEPTH, 8, FIFO entries; power of 2, range 2..128.
- TAG_W, 8, sequence tag width; tag wraps modulo 2^TAG_W.
- BASE_ADR, 32'h3000_0000, Wishbone base address; decode compares wbs_adr_i[31:4] to BASE_ADR[31:4].

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  reset; synchronous, active-high.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  write enable.
- wbs_sel_i  in  4  byte selects.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  address.
- wbs_ack_o  out  1  acknowledge.
- wbs_dat_o  out  32  read data.
- sum_i  in  4  adder sum.
- co_i  in  1  adder carry-out.
- sample_i  in  1  capture strobe; asynchronous (GPIO).
- irq_o  out  1  results-pending interrupt.

Behaviour:
- Clock and reset:
  - One clock, wb_clk_i.
  - wb_rst_i is synchronous and active-high.
  - Reset clears all state: FIFO empty, tag=0, enable=0, irq_en=0, overflow=0.
  - Reset values of outputs: wbs_ack_o=0, wbs_dat_o=0, irq_o=0.
  - Reset asserted mid-transaction aborts it; no ack is issued.
- Sample path:
  - sample_i passes through a 2-flop synchronizer, then a third flop for edge detection.
  - Push pulse = sync & ~prev; one cycle per rising edge.
  - sum_i and co_i are sampled in the push cycle; they are assumed stable by then.
  - Latency from a sample_i rise to the entry being visible in STATUS.count is 4 clocks.
- Push rules:
  - Push only when enable=1.
  - Entry = {tag, co_i, sum_i}.
  - Tag increments on every push pulse while enabled, whether the entry is accepted or dropped, so software can see gaps.
  - Full and no pop this cycle: entry is dropped and overflow (sticky) is set.
  - Full with a pop in the same cycle: entry is accepted; count stays DEPTH.
- Wishbone:
  - req = cyc & stb & address match.
  - Ack is registered and lasts exactly 1 cycle: ack <= req & ~ack. This gives 1-cycle latency and no back-to-back ack.
  - wbs_dat_o is registered with ack and is 0 in cycles without ack.
  - Unmatched addresses never ack.
- Register map (offset: contents):
  - 0x0 DATA (read-only):
    - Layout: [4:0]={co,sum}, [15:8]=tag (for TAG_W=8), [31]=entry valid.
    - Reading with ack pops one entry when non-empty.
    - Reading when empty returns 0 and changes nothing.
    - Writes are ignored.
  - 0x4 STATUS:
    - Layout: [7:0]=count, [8]=empty, [9]=full, [10]=overflow.
    - Writing 1 to bit 10 with sel[1]=1 clears overflow (W1C).
    - If an overflow event coincides with the clear, the set wins.
  - 0x8 CTRL:
    - Layout: [0]=enable, [1]=irq_en, [2]=clear; writes need sel[0].
    - clear self-clears and reads as 0. It flushes the FIFO (pointers and count to 0); tag and overflow are untouched.
    - A push in the same cycle as clear is discarded, but tag still increments.
  - 0xC: reads 0; writes ignored.
- Register effects take place in the ack cycle.
- irq_o = irq_en & ~empty, driven from registered state; no glitches.

Decomposition:
- Package sum_capture_pkg holds:
  - register offsets (OFS_DATA=0x0, OFS_STATUS=0x4, OFS_CTRL=0x8);
  - bit-position constants for STATUS and CTRL;
  - the entry typedef {tag, co, sum}.
- One sub-module, sync_fifo: parameterized DEPTH/WIDTH, push/pop/flush, full/empty/count.
  - It accepts a push while full only when pop is asserted in the same cycle.
- The top level holds the synchronizer, edge detect, tag counter, Wishbone decode and CSRs.

Test Plan:
- Reset, write CTRL=0x1, pulse sample_i with sum_i=4'hA, co_i=1 -> STATUS.count=1 four clocks later; DATA read returns 0x8000_001A, tag=0; a following STATUS read returns 0x100 (empty).
- Enable, take 9 samples with DEPTH=8 -> STATUS=0x000_0608 (count 8, full, overflow); drain 8 entries: tags 0..7, then DATA=0; a W1C of 0x400 clears overflow; the next sample carries tag 9.
- Set irq_en=1, take one sample -> irq_o rises together with the count increment; it falls on the ack of the DATA read that empties the FIFO.
- FIFO full, and a sample push lands in the same cycle as a DATA-read pop -> count stays 8, no overflow, the new entry is last out.
- Set clear together with a coincident push while 3 entries are held -> count=0, empty=1, tag advanced by 1, overflow unchanged.
- Addressing and reset:
  - Access BASE_ADR+0x10 -> no ack within 4 cycles.
  - Assert wb_rst_i during a pending req -> ack=0, and all CSRs read back at reset values afterwards.

Source files
------------

// File: rtl/sum_capture_fifo_pkg.sv
// Shared constants for the adder-result capture block: register offsets,
// CSR bit positions and the captured-entry layout.
package sum_capture_pkg;

    localparam logic [3:0] OFS_DATA   = 4'h0;
    localparam logic [3:0] OFS_STATUS = 4'h4;
    localparam logic [3:0] OFS_CTRL   = 4'h8;

    localparam int STAT_EMPTY_BIT  = 8;
    localparam int STAT_FULL_BIT   = 9;
    localparam int STAT_OVF_BIT    = 10;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQ_EN_BIT = 1;
    localparam int CTRL_CLEAR_BIT  = 2;

    localparam int DATA_TAG_LSB    = 8;
    localparam int DATA_VALID_BIT  = 31;

    localparam int DEF_TAG_W       = 8;

    typedef struct packed {
        logic [DEF_TAG_W-1:0] tag;
        logic                 co;
        logic [3:0]           sum;
    } entry_t;

endpackage

// File: rtl/sum_capture_fifo_if.sv
// Wishbone slave bus bundle used by the capture FIFO; the SoC side is the master.
interface sum_capture_fifo_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_dat_i;
    logic [31:0] wbs_adr_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/sum_capture_fifo_sync_fifo.sv
// Small synchronous FIFO with flush; a push while full is taken only when
// a pop happens in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 13
) (
    input  logic                       clk,
    input  logic                       srst,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic                       i_flush,
    input  logic [WIDTH-1:0]           i_wr_data,
    output logic [WIDTH-1:0]           o_rd_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_full;
    logic             w_empty;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~i_flush & ~w_empty;
    assign w_do_push = i_push & ~i_flush & (~w_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (srst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_wr_data;
    end

    // Combinational head read so the bus can return the entry with its ack.
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_count   = r_count;
endmodule

// File: rtl/sum_capture_fifo.sv
// Captures tagged {carry, sum} adder results on each sample_i rising edge
// into a FIFO that the SoC drains over Wishbone; irq_o flags pending data.
module sum_capture_fifo
    import sum_capture_pkg::*;
#(
    parameter int          DEPTH    = 8,
    parameter int          TAG_W    = 8,
    parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_i,
    sum_capture_fifo_if.slave  wbs,
    input  logic [3:0]         sum_i,
    input  logic               co_i,
    input  logic               sample_i,
    output logic               irq_o
);
    localparam int EW = TAG_W + 5;
    localparam int CW = $clog2(DEPTH) + 1;

    logic             r_sync1, r_sync2, r_prev, r_push;
    logic [TAG_W-1:0] r_tag;
    logic             r_enable, r_irq_en, r_ovf, r_ack;
    logic [31:0]      r_dat;

    logic             w_req, w_ack_next, w_rd, w_wr;
    logic             w_push, w_pop, w_flush, w_ovf_set, w_ovf_clr, w_ctrl_wr;
    logic             w_full, w_empty;
    logic [CW-1:0]    w_count;
    logic [EW-1:0]    w_head;
    logic [31:0]      w_rd_word;
    logic [3:0]       w_ofs;
    logic             w_unused;

    // Two flops resynchronise the GPIO strobe, the third gives the edge,
    // and the pulse itself is registered so the entry lands 4 clocks later.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_push  <= 1'b0;
        end else begin
            r_sync1 <= sample_i;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_push  <= r_sync2 & ~r_prev;
        end
    end

    assign w_ofs      = wbs.wbs_adr_i[3:0];
    assign w_req      = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                        (wbs.wbs_adr_i[31:4] == BASE_ADR[31:4]);
    assign w_ack_next = w_req & ~r_ack;
    assign w_rd       = w_ack_next & ~wbs.wbs_we_i;
    assign w_wr       = w_ack_next & wbs.wbs_we_i;
    assign w_ctrl_wr  = w_wr & (w_ofs == OFS_CTRL) & wbs.wbs_sel_i[0];

    assign w_push     = r_push & r_enable;
    assign w_pop      = w_rd & (w_ofs == OFS_DATA) & ~w_empty;
    assign w_flush    = w_ctrl_wr & wbs.wbs_dat_i[CTRL_CLEAR_BIT];
    assign w_ovf_set  = w_push & w_full & ~w_pop & ~w_flush;
    assign w_ovf_clr  = w_wr & (w_ofs == OFS_STATUS) & wbs.wbs_sel_i[1] &
                        wbs.wbs_dat_i[STAT_OVF_BIT];

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (wb_clk_i),
        .srst      (wb_rst_i),
        .i_push    (w_push),
        .i_pop     (w_pop),
        .i_flush   (w_flush),
        .i_wr_data ({r_tag, co_i, sum_i}),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (w_count)
    );

    always_comb begin
        w_rd_word = '0;
        case (w_ofs)
            OFS_DATA: begin
                if (!w_empty) begin
                    w_rd_word[DATA_VALID_BIT]             = 1'b1;
                    w_rd_word[DATA_TAG_LSB +: TAG_W]      = w_head[EW-1 -: TAG_W];
                    w_rd_word[4:0]                        = w_head[4:0];
                end
            end
            OFS_STATUS: begin
                w_rd_word[7:0]            = 8'(w_count);
                w_rd_word[STAT_EMPTY_BIT] = w_empty;
                w_rd_word[STAT_FULL_BIT]  = w_full;
                w_rd_word[STAT_OVF_BIT]   = r_ovf;
            end
            OFS_CTRL: begin
                w_rd_word[CTRL_EN_BIT]     = r_enable;
                w_rd_word[CTRL_IRQ_EN_BIT] = r_irq_en;
            end
            default: w_rd_word = '0;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack    <= 1'b0;
            r_dat    <= '0;
            r_tag    <= '0;
            r_enable <= 1'b0;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_ack <= w_ack_next;
            r_dat <= w_rd ? w_rd_word : 32'd0;
            // Tag counts every enabled pulse, including dropped ones, so gaps show.
            if (w_push) r_tag <= r_tag + TAG_W'(1);
            if (w_ctrl_wr) begin
                r_enable <= wbs.wbs_dat_i[CTRL_EN_BIT];
                r_irq_en <= wbs.wbs_dat_i[CTRL_IRQ_EN_BIT];
            end
            r_ovf <= w_ovf_set | (r_ovf & ~w_ovf_clr);
        end
    end

    assign wbs.wbs_ack_o = r_ack;
    assign wbs.wbs_dat_o = r_dat;
    assign irq_o         = r_irq_en & ~w_empty;

    assign w_unused = ^{wbs.wbs_sel_i[3:2], wbs.wbs_dat_i[31:11], wbs.wbs_dat_i[9:3]};
endmodule

// File: tb/tb_sum_capture_fifo.sv
// Bench for sum_capture_fifo: vector table plus scoreboard of expected DATA words.
module tb_sum_capture_fifo;
    import sum_capture_pkg::*;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] sum_i;
    logic       co_i;
    logic       sample_i;
    logic       irq_o;

    sum_capture_fifo_if wbs_if();

    sum_capture_fifo #(
        .DEPTH    (DEPTH),
        .TAG_W    (8),
        .BASE_ADR (BASE)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .wbs      (wbs_if),
        .sum_i    (sum_i),
        .co_i     (co_i),
        .sample_i (sample_i),
        .irq_o    (irq_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  sum;
        logic        co;
        logic [31:0] exp;
    } vec_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] sb[$];
    int          m_tag = 0;
    logic        m_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input entry_t e);
        return 32'h8000_0000 | (32'(e.tag) << 8) | 32'({e.co, e.sum});
    endfunction

    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                             input logic [3:0] sel, output logic [31:0] rdat, output logic acked);
        @(negedge clk);
        wbs_if.wbs_cyc_i = 1'b1;
        wbs_if.wbs_stb_i = 1'b1;
        wbs_if.wbs_we_i  = we;
        wbs_if.wbs_adr_i = adr;
        wbs_if.wbs_dat_i = wdat;
        wbs_if.wbs_sel_i = sel;
        acked = 1'b0;
        rdat  = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wbs_if.wbs_ack_o) begin
                acked = 1'b1;
                rdat  = wbs_if.wbs_dat_o;
                break;
            end
        end
        wbs_if.wbs_cyc_i = 1'b0;
        wbs_if.wbs_stb_i = 1'b0;
        wbs_if.wbs_we_i  = 1'b0;
        $display("wb %s adr=%h wdat=%h rdat=%h ack=%0d", we ? "wr" : "rd", adr, wdat, rdat, acked);
    endtask

    task automatic rd_check(input string name, input logic [31:0] adr, input logic [31:0] exp);
        logic [31:0] r;
        logic        a;
        wb_access(1'b0, adr, 32'd0, 4'hF, r, a);
        check({name, " ack"}, 32'(a), 32'd1);
        check(name, r, exp);
    endtask

    task automatic wr(input string name, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel);
        logic [31:0] r;
        logic        a;
        wb_access(1'b1, adr, dat, sel, r, a);
        check({name, " ack"}, 32'(a), 32'd1);
        if (adr == BASE + 32'h8 && sel[0]) begin
            m_en = dat[0];
            if (dat[2]) sb.delete();
        end
    endtask

    task automatic rd_sb(input string name);
        logic [31:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : 32'd0;
        rd_check(name, BASE, exp);
    endtask

    task automatic model_push(input logic [3:0] s, input logic c);
        entry_t e;
        if (m_en) begin
            e.tag = 8'(m_tag);
            e.co  = c;
            e.sum = s;
            m_tag++;
            if (sb.size() < DEPTH) sb.push_back(mk(e));
        end
    endtask

    task automatic sample(input logic [3:0] s, input logic c);
        @(negedge clk);
        sum_i    = s;
        co_i     = c;
        sample_i = 1'b1;
        repeat (2) @(negedge clk);
        sample_i = 1'b0;
        repeat (4) @(negedge clk);
        model_push(s, c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        m_tag = 0;
        m_en  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[5];
        logic [31:0] exp;
        entry_t      e;

        vecs[0] = '{4'h0, 1'b0, 32'h8000_0100};
        vecs[1] = '{4'hF, 1'b1, 32'h8000_021F};
        vecs[2] = '{4'h5, 1'b0, 32'h8000_0305};
        vecs[3] = '{4'h7, 1'b1, 32'h8000_0417};
        vecs[4] = '{4'h9, 1'b0, 32'h8000_0509};

        rst = 1'b1;
        wbs_if.wbs_cyc_i = 1'b0;
        wbs_if.wbs_stb_i = 1'b0;
        wbs_if.wbs_we_i  = 1'b0;
        wbs_if.wbs_sel_i = 4'h0;
        wbs_if.wbs_dat_i = '0;
        wbs_if.wbs_adr_i = '0;
        sum_i = 4'h0;
        co_i = 1'b0;
        sample_i = 1'b0;
        repeat (3) @(negedge clk);
        check("reset ack", 32'(wbs_if.wbs_ack_o), 32'd0);
        check("reset dat", wbs_if.wbs_dat_o, 32'd0);
        check("reset irq", 32'(irq_o), 32'd0);
        rst = 1'b0;
        rd_check("reset STATUS", BASE + 32'h4, 32'h100);
        rd_check("reset CTRL", BASE + 32'h8, 32'h0);

        // Single capture, then table-driven captures with tags 1..5
        wr("CTRL en", BASE + 32'h8, 32'h1, 4'h1);
        sample(4'hA, 1'b1);
        rd_check("t1 STATUS", BASE + 32'h4, 32'h001);
        rd_check("t1 DATA", BASE, 32'h8000_001A);
        void'(sb.pop_front());
        rd_check("t1 STATUS empty", BASE + 32'h4, 32'h100);
        for (int i = 0; i < 5; i++) begin
            sample(vecs[i].sum, vecs[i].co);
            rd_check($sformatf("vec%0d DATA", i), BASE, vecs[i].exp);
            void'(sb.pop_front());
        end

        // Overflow: 9 samples into 8 entries, drain, W1C, tag gap
        do_reset();
        wr("CTRL en", BASE + 32'h8, 32'h1, 4'h1);
        for (int i = 0; i < 9; i++) sample(4'(i), i[0]);
        rd_check("ovf STATUS", BASE + 32'h4, 32'h608);
        for (int i = 0; i < 8; i++) rd_sb($sformatf("drain%0d", i));
        rd_check("drained DATA", BASE, 32'h0);
        wr("W1C ovf", BASE + 32'h4, 32'h400, 4'b0010);
        rd_check("W1C STATUS", BASE + 32'h4, 32'h100);
        sample(4'h6, 1'b1);
        rd_sb("tag after gap");

        // Interrupt timing: rises with count, falls on emptying ack
        wr("CTRL en+irq", BASE + 32'h8, 32'h3, 4'h1);
        @(negedge clk);
        sum_i = 4'h3;
        co_i = 1'b0;
        sample_i = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("irq before capture", 32'(irq_o), 32'd0);
        @(posedge clk);
        #1 check("irq at capture", 32'(irq_o), 32'd1);
        model_push(4'h3, 1'b0);
        @(negedge clk);
        sample_i = 1'b0;
        repeat (3) @(negedge clk);
        wbs_if.wbs_cyc_i = 1'b1;
        wbs_if.wbs_stb_i = 1'b1;
        wbs_if.wbs_we_i  = 1'b0;
        wbs_if.wbs_adr_i = BASE;
        @(posedge clk);
        #1;
        exp = sb.pop_front();
        check("irq read ack", 32'(wbs_if.wbs_ack_o), 32'd1);
        check("irq read DATA", wbs_if.wbs_dat_o, exp);
        check("irq after pop", 32'(irq_o), 32'd0);
        $display("wb rd adr=%h rdat=%h (irq sequence)", BASE, wbs_if.wbs_dat_o);
        @(negedge clk);
        wbs_if.wbs_cyc_i = 1'b0;
        wbs_if.wbs_stb_i = 1'b0;
        wr("CTRL en", BASE + 32'h8, 32'h1, 4'h1);

        // Full FIFO: push and pop in the same cycle
        for (int i = 0; i < 8; i++) sample(4'(15 - i), 1'b1);
        @(negedge clk);
        sum_i = 4'h4;
        co_i = 1'b0;
        sample_i = 1'b1;
        repeat (3) @(negedge clk);
        sample_i = 1'b0;
        wbs_if.wbs_cyc_i = 1'b1;
        wbs_if.wbs_stb_i = 1'b1;
        wbs_if.wbs_we_i  = 1'b0;
        wbs_if.wbs_adr_i = BASE;
        @(negedge clk);
        exp = sb.pop_front();
        check("push+pop ack", 32'(wbs_if.wbs_ack_o), 32'd1);
        check("push+pop DATA", wbs_if.wbs_dat_o, exp);
        $display("wb rd adr=%h rdat=%h (push+pop)", BASE, wbs_if.wbs_dat_o);
        wbs_if.wbs_cyc_i = 1'b0;
        wbs_if.wbs_stb_i = 1'b0;
        e.tag = 8'(m_tag);
        e.co  = 1'b0;
        e.sum = 4'h4;
        sb.push_back(mk(e));
        m_tag++;
        repeat (5) @(negedge clk);
        rd_check("push+pop STATUS", BASE + 32'h4, 32'h208);
        for (int i = 0; i < 8; i++) rd_sb($sformatf("full drain%0d", i));
        rd_check("full drained DATA", BASE, 32'h0);

        // Clear coinciding with a push while 3 entries are held
        for (int i = 0; i < 3; i++) sample(4'(i + 1), 1'b0);
        rd_check("pre-clear STATUS", BASE + 32'h4, 32'h003);
        @(negedge clk);
        sum_i = 4'hC;
        co_i = 1'b0;
        sample_i = 1'b1;
        repeat (3) @(negedge clk);
        sample_i = 1'b0;
        wbs_if.wbs_cyc_i = 1'b1;
        wbs_if.wbs_stb_i = 1'b1;
        wbs_if.wbs_we_i  = 1'b1;
        wbs_if.wbs_adr_i = BASE + 32'h8;
        wbs_if.wbs_dat_i = 32'h5;
        wbs_if.wbs_sel_i = 4'h1;
        @(negedge clk);
        check("clear ack", 32'(wbs_if.wbs_ack_o), 32'd1);
        $display("wb wr adr=%h wdat=%h (clear+push)", BASE + 32'h8, 32'h5);
        wbs_if.wbs_cyc_i = 1'b0;
        wbs_if.wbs_stb_i = 1'b0;
        wbs_if.wbs_we_i  = 1'b0;
        sb.delete();
        m_tag++;
        repeat (4) @(negedge clk);
        rd_check("post-clear STATUS", BASE + 32'h4, 32'h100);
        rd_check("post-clear CTRL", BASE + 32'h8, 32'h1);
        sample(4'h3, 1'b1);
        rd_sb("tag after clear");

        // Addressing: outside window never acks; 0xC reads 0
        begin
            logic [31:0] r;
            logic        a;
            wb_access(1'b0, BASE + 32'h10, 32'd0, 4'hF, r, a);
            check("no ack +0x10", 32'(a), 32'd0);
        end
        wr("wr 0xC", BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        rd_check("rd 0xC", BASE + 32'hC, 32'h0);

        // Reset during a pending request
        wr("CTRL en+irq", BASE + 32'h8, 32'h3, 4'h1);
        sample(4'h2, 1'b0);
        @(negedge clk);
        wbs_if.wbs_cyc_i = 1'b1;
        wbs_if.wbs_stb_i = 1'b1;
        wbs_if.wbs_we_i  = 1'b0;
        wbs_if.wbs_adr_i = BASE + 32'h4;
        rst = 1'b1;
        @(negedge clk);
        check("rst req ack", 32'(wbs_if.wbs_ack_o), 32'd0);
        check("rst req dat", wbs_if.wbs_dat_o, 32'd0);
        check("rst req irq", 32'(irq_o), 32'd0);
        wbs_if.wbs_cyc_i = 1'b0;
        wbs_if.wbs_stb_i = 1'b0;
        rst = 1'b0;
        sb.delete();
        m_tag = 0;
        m_en  = 1'b0;
        rd_check("post-rst STATUS", BASE + 32'h4, 32'h100);
        rd_check("post-rst CTRL", BASE + 32'h8, 32'h0);
        rd_check("post-rst DATA", BASE, 32'h0);
        wr("CTRL en", BASE + 32'h8, 32'h1, 4'h1);
        sample(4'h1, 1'b1);
        rd_check("post-rst tag0", BASE, 32'h8000_0011);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
